run_parity_detector: RTL and testbench

RUN_PARITY_DETECTOR -- requirements
Module: run_parity_detector

---
 rtl/run_parity_detector.sv | 84 ++++++++
 tb/tb_run_parity_detector.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/run_parity_detector.sv
// run_parity_detector
// Per-channel serial monitor. Each channel counts consecutive sampled 1s
// (saturating at RUN_LEN), flags when a run of RUN_LEN or more is in progress,
// and keeps the running parity of all sampled 1s. A shared mode select picks
// which of those flags is registered onto data_out.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous clear of all channel state and data_out
//   sample_en  qualifies data_in for the current edge
//   mode       00: run|par  01: run  10: par  11: run&par
//   data_in    one serial bit per channel
//   data_out   registered per-channel result
//   any_out    OR of data_out
module run_parity_detector #(
  parameter int CHANNELS = 4,
  parameter int RUN_LEN  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                sample_en,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] data_in,
  output logic [CHANNELS-1:0] data_out,
  output logic                any_out
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  // A 1 arriving while the count already holds RUN_LEN-1 completes a run.
  localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN - 1);

  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] run_q;
  logic [CHANNELS-1:0] par_q;
  logic [CHANNELS-1:0] fout;

  // Output function uses the flag values from before the current edge, which
  // gives data_out its one-edge lag behind the flags.
  always_comb begin
    fout = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode)
        2'b00:   fout[i] = run_q[i] | par_q[i];
        2'b01:   fout[i] = run_q[i];
        2'b10:   fout[i] = par_q[i];
        default: fout[i] = run_q[i] & par_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      run_q    <= '0;
      par_q    <= '0;
      data_out <= '0;
    end else if (clear) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      run_q    <= '0;
      par_q    <= '0;
      data_out <= '0;
    end else begin
      if (sample_en) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (data_in[i]) begin
            if (cnt[i] != RUN_MAX) cnt[i] <= cnt[i] + 1'b1;
          end else begin
            cnt[i] <= '0;
          end
          run_q[i] <= data_in[i] && (cnt[i] >= RUN_THR);
          par_q[i] <= par_q[i] ^ data_in[i];
        end
      end
      data_out <= fout;
    end
  end

  assign any_out = |data_out;

endmodule

// File: tb/tb_run_parity_detector.sv
// Testbench for run_parity_detector (CHANNELS=4, RUN_LEN=3). The reference
// model tracks, per channel, the length of the current streak of sampled 1s
// and the total count of sampled 1s; run and parity follow from those.
module tb_run_parity_detector;
  localparam int CH = 4;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          sample_en;
  logic [1:0]    mode;
  logic [CH-1:0] data_in;
  logic [CH-1:0] data_out;
  logic          any_out;

  run_parity_detector #(.CHANNELS(CH), .RUN_LEN(RL)) dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .mode(mode), .data_in(data_in), .data_out(data_out), .any_out(any_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            streak [CH];
  int            ones   [CH];
  logic [CH-1:0] exp_out;

  function automatic logic fsel(logic [1:0] m, logic r, logic p);
    case (m)
      2'b00:   return r | p;
      2'b01:   return r;
      2'b10:   return p;
      default: return r & p;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      streak[i] = 0;
      ones[i]   = 0;
    end
    exp_out = '0;
  endtask

  // Drive one edge worth of inputs (called at a falling edge), advance the
  // model at the rising edge, then compare outputs at the next falling edge.
  task automatic cycle(logic clr, logic en, logic [1:0] md, logic [CH-1:0] d);
    clear     = clr;
    sample_en = en;
    mode      = md;
    data_in   = d;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++)
        exp_out[i] = fsel(md, streak[i] >= RL, (ones[i] % 2) == 1);
      if (en) begin
        for (int i = 0; i < CH; i++) begin
          if (d[i]) begin
            streak[i]++;
            ones[i]++;
          end else begin
            streak[i] = 0;
          end
        end
      end
    end
    @(negedge clk);
    chk("data_out", 32'(data_out), 32'(exp_out));
    chk("any_out", 32'(any_out), 32'(|exp_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    md;
    logic [CH-1:0] d;
    int            dens;

    rst = 1'b1; clear = 1'b0; sample_en = 1'b0; mode = 2'b00; data_in = '0;
    model_reset();
    #12;
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_any_out", 32'(any_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Run detection on ch0, mode run-only
    cycle(0, 1, 2'b01, 4'b0001);
    cycle(0, 1, 2'b01, 4'b0001);
    cycle(0, 1, 2'b01, 4'b0001);
    cycle(0, 1, 2'b01, 4'b0001);
    chk("run_edge4", 32'(data_out[0]), 32'h1);
    cycle(0, 1, 2'b01, 4'b0000);
    chk("run_edge5", 32'(data_out[0]), 32'h1);
    cycle(0, 0, 2'b01, 4'b0000);
    chk("run_edge6", 32'(data_out[0]), 32'h0);

    // Parity on ch1, mode parity-only
    cycle(1, 0, 2'b10, 4'b0000);
    cycle(0, 1, 2'b10, 4'b0010);
    cycle(0, 1, 2'b10, 4'b0010);
    chk("par_edge2", 32'(data_out[1]), 32'h1);
    cycle(0, 1, 2'b10, 4'b0010);
    chk("par_edge3", 32'(data_out[1]), 32'h0);
    cycle(0, 1, 2'b10, 4'b0000);
    chk("par_edge4", 32'(data_out[1]), 32'h1);
    cycle(0, 0, 2'b10, 4'b0000);
    chk("par_edge5", 32'(data_out[1]), 32'h1);

    // Hold across sample_en=0
    cycle(1, 0, 2'b01, 4'b0000);
    cycle(0, 1, 2'b01, 4'b0001);
    cycle(0, 1, 2'b01, 4'b0001);
    cycle(0, 0, 2'b01, 4'b0000);
    cycle(0, 0, 2'b01, 4'b0000);
    cycle(0, 1, 2'b01, 4'b0001);
    cycle(0, 0, 2'b01, 4'b0000);
    chk("hold_run", 32'(data_out[0]), 32'h1);

    // AND mode with independent channels
    cycle(1, 0, 2'b11, 4'b0000);
    cycle(0, 1, 2'b11, 4'b1100);
    cycle(0, 1, 2'b11, 4'b1100);
    cycle(0, 1, 2'b11, 4'b0100);
    cycle(0, 0, 2'b11, 4'b0000);
    chk("and_mode", 32'(data_out), 32'h4);
    chk("and_any", 32'(any_out), 32'h1);

    // Clear beats sample_en
    cycle(1, 1, 2'b00, 4'b1111);
    chk("clear_prio", 32'(data_out), 32'h0);
    cycle(0, 0, 2'b10, 4'b0000);
    chk("clear_par", 32'(data_out), 32'h0);

    // Asynchronous reset between edges
    cycle(0, 1, 2'b00, 4'b1111);
    cycle(0, 1, 2'b00, 4'b1111);
    chk("pre_rst_all", 32'(data_out), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(data_out), 32'h0);
    chk("async_rst_any", 32'(any_out), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1, 2'b10, 4'b1111);
    cycle(0, 0, 2'b10, 4'b0000);
    chk("post_rst_par", 32'(data_out), 32'hF);

    // Randomized traffic
    md = 2'b00;
    dens = 2;
    for (int n = 0; n < 800; n++) begin
      if (n % 40 == 0) dens = $urandom_range(1, 4);
      for (int i = 0; i < CH; i++) d[i] = ($urandom_range(0, 3) < dens);
      if ($urandom_range(0, 7) == 0) md = 2'($urandom);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, md, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
